// File: rtl/fifo_umbral.sv
// Synchronous occupancy-reporting FIFO with programmable almost-full/almost-empty thresholds.
// Optional threshold legality check: define FIFO_UMBRAL_THR_CHECK_EN.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   af_thr,
    input  logic [ADDR_WIDTH:0]   ae_thr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = CNT_ONE[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   AF_DEF  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0]   AE_DEF  = CNT_ONE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wp_reg, wp_next;
    logic [ADDR_WIDTH-1:0] rp_reg, rp_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [ADDR_WIDTH:0]   af_reg, af_next;
    logic [ADDR_WIDTH:0]   ae_reg, ae_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic                  valid_reg, valid_next;
    logic                  error_reg, error_next;

    logic rd_acc;
    logic wr_acc;
    logic mem_we;
    logic overflow;
    logic underflow;

    // Status flags are pure compares of the registered count.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= af_reg);
    assign almost_empty = (count_reg <= ae_reg);

    assign count     = count_reg;
    assign data_out  = data_out_reg;
    assign valid_out = valid_reg;
    assign error     = error_reg;

    // A pop frees a slot in the same cycle, so a push at full passes through.
    assign rd_acc    = rd_en && !empty;
    assign wr_acc    = wr_en && (!full || rd_acc);
    assign overflow  = wr_en && full && !rd_en;
    assign underflow = rd_en && empty;
    assign mem_we    = wr_acc && !init && !reset;

`ifdef FIFO_UMBRAL_THR_CHECK_EN
    logic thr_bad;
    assign thr_bad = (af_thr == '0) || (af_thr > DEPTH_C) ||
                     (ae_thr >= af_thr) || (ae_thr > DEPTH_C);
`endif

    always_comb begin
        wp_next       = wp_reg;
        rp_next       = rp_reg;
        count_next    = count_reg;
        af_next       = af_reg;
        ae_next       = ae_reg;
        data_out_next = data_out_reg;
        valid_next    = 1'b0;
        error_next    = error_reg;

        if (init) begin
            wp_next    = '0;
            rp_next    = '0;
            count_next = '0;
            af_next    = af_thr;
            ae_next    = ae_thr;
            error_next = 1'b0;
`ifdef FIFO_UMBRAL_THR_CHECK_EN
            if (thr_bad) begin
                af_next    = AF_DEF;
                ae_next    = AE_DEF;
                error_next = 1'b1;
            end
`endif
        end else begin
            if (rd_acc) begin
                data_out_next = mem[rp_reg];
                rp_next       = rp_reg + PTR_ONE;
                valid_next    = 1'b1;
            end
            if (wr_acc) begin
                wp_next = wp_reg + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
            if (overflow || underflow) begin
                error_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            af_reg       <= AF_DEF;
            ae_reg       <= AE_DEF;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            wp_reg       <= wp_next;
            rp_reg       <= rp_next;
            count_reg    <= count_next;
            af_reg       <= af_next;
            ae_reg       <= ae_next;
            data_out_reg <= data_out_next;
            valid_reg    <= valid_next;
            error_reg    <= error_next;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wp_reg] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral (DEPTH=4, DATA_WIDTH=6); follows FIFO_UMBRAL_THR_CHECK_EN if defined.
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic [2:0] af_thr = 3'd0;
    logic [2:0] ae_thr = 3'd0;
    logic       wr_en = 1'b0;
    logic [5:0] data_in = 6'd0;
    logic       rd_en = 1'b0;
    logic [5:0] data_out;
    logic       valid_out;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .af_thr      (af_thr),
        .ae_thr      (ae_thr),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .error       (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [5:0] mq[$];      // words currently held
    logic [5:0] exp_q[$];   // words expected on data_out, in order
    int         m_count = 0;
    int         m_af = 3;
    int         m_ae = 1;
    logic       m_err = 1'b0;
    logic       m_valid = 1'b0;
    logic [5:0] m_dout = 6'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".count"}, 32'(count), 32'(m_count));
        chk({ctx, ".empty"}, 32'(empty), 32'(m_count == 0));
        chk({ctx, ".full"}, 32'(full), 32'(m_count == 4));
        chk({ctx, ".afull"}, 32'(almost_full), 32'(m_count >= m_af));
        chk({ctx, ".aempty"}, 32'(almost_empty), 32'(m_count <= m_ae));
        chk({ctx, ".error"}, 32'(error), 32'(m_err));
        chk({ctx, ".valid"}, 32'(valid_out), 32'(m_valid));
        if (valid_out) begin
            if (exp_q.size() > 0) begin
                chk({ctx, ".data"}, 32'(data_out), 32'(exp_q.pop_front()));
            end else begin
                chk({ctx, ".extra_valid"}, 32'(valid_out), 32'(0));
            end
        end else begin
            chk({ctx, ".hold"}, 32'(data_out), 32'(m_dout));
        end
    endtask

    task automatic step(input string ctx, input logic w, input logic [5:0] d, input logic r);
        logic rd_acc;
        logic wr_acc;
        logic [5:0] popped;
        @(negedge clk);
        reset = 1'b0; init = 1'b0;
        wr_en = w; data_in = d; rd_en = r;
        rd_acc = r && (m_count > 0);
        wr_acc = w && ((m_count < 4) || rd_acc);
        if ((w && m_count == 4 && !r) || (r && m_count == 0)) m_err = 1'b1;
        m_valid = rd_acc;
        if (rd_acc) begin
            popped = mq.pop_front();
            exp_q.push_back(popped);
            m_dout = popped;
        end
        if (wr_acc) mq.push_back(d);
        if (wr_acc && !rd_acc) m_count++;
        if (rd_acc && !wr_acc) m_count--;
        @(posedge clk); #1;
        $display("txn %s wr=%0b din=%02h rd=%0b -> cnt=%0d dout=%02h vld=%0b err=%0b",
                 ctx, w, d, r, count, data_out, valid_out, error);
        check_outputs(ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; init = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; data_in = 6'h2a;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        mq.delete(); exp_q.delete();
        m_count = 0; m_af = 3; m_ae = 1; m_err = 1'b0; m_valid = 1'b0; m_dout = 6'd0;
        $display("txn reset -> cnt=%0d dout=%02h vld=%0b err=%0b", count, data_out, valid_out, error);
        check_outputs("reset");
        chk("reset.dout_zero", 32'(data_out), 32'(0));
    endtask

    task automatic do_init(input logic [2:0] af, input logic [2:0] ae);
        @(negedge clk);
        reset = 1'b0; init = 1'b1;
        af_thr = af; ae_thr = ae;
        wr_en = 1'b1; rd_en = 1'b1; data_in = 6'h3f;
        @(posedge clk); #1;
        mq.delete(); exp_q.delete();
        m_count = 0; m_err = 1'b0; m_valid = 1'b0;
        m_af = int'(af); m_ae = int'(ae);
`ifdef FIFO_UMBRAL_THR_CHECK_EN
        if (af == 0 || af > 4 || ae >= af || ae > 4) begin
            m_af = 3; m_ae = 1; m_err = 1'b1;
        end
`endif
        $display("txn init af=%0d ae=%0d -> cnt=%0d err=%0b", af, ae, count, error);
        check_outputs("init");
    endtask

    initial begin
        do_reset();

        // Fill to full, then overflow
        do_init(3'd3, 3'd1);
        for (int i = 1; i <= 4; i++) step("fill", 1'b1, 6'(i), 1'b0);
        step("overflow", 1'b1, 6'h05, 1'b0);
        chk("overflow.count", 32'(count), 32'(4));

        // Drain in order
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 6'h00, 1'b1);
        chk("drain.empty", 32'(empty), 32'(1));

        // Underflow, cleared by init
        do_init(3'd3, 3'd1);
        step("underflow", 1'b0, 6'h00, 1'b1);
        chk("underflow.err", 32'(error), 32'(1));
        do_init(3'd3, 3'd1);
        chk("init.clears_err", 32'(error), 32'(0));

        // Pass-through at full across pointer wrap
        for (int i = 0; i < 4; i++) step("prefill", 1'b1, 6'(8'h20 + i), 1'b0);
        for (int i = 0; i < 8; i++) step("thru_full", 1'b1, 6'(8'h10 + i), 1'b1);
        for (int i = 0; i < 4; i++) step("post_drain", 1'b0, 6'h00, 1'b1);

        // Simultaneous push and pop while empty
        step("both_empty", 1'b1, 6'h3a, 1'b1);
        chk("both_empty.count", 32'(count), 32'(1));
        step("pop_single", 1'b0, 6'h00, 1'b1);

        // Inverted threshold pair
        do_init(3'd2, 3'd3);
        for (int i = 0; i < 3; i++) step("thr", 1'b1, 6'(8'h30 + i), 1'b0);

        // Boundary thresholds, then random traffic with occasional init
        do_init(3'd4, 3'd0);
        for (int i = 0; i < 5; i++) step("thr_edge", 1'b1, 6'(i), 1'b0);
        for (int i = 0; i < 5; i++) step("thr_edge_rd", 1'b0, 6'h00, 1'b1);
        do_init(3'd3, 3'd1);
        for (int i = 0; i < 150; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)));
            if (i == 75) do_init(3'd2, 3'd1);
        end

        // Reset in the middle of traffic
        step("pre_reset", 1'b1, 6'h11, 1'b0);
        do_reset();
        step("post_reset", 1'b1, 6'h22, 1'b0);
        step("post_reset_rd", 1'b0, 6'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
